// File: rtl/multicycle_control_pkg.sv
// Shared types for the multicycle controller: FSM state encoding and the
// RV32 base opcodes that the decoder recognises.
package multicycle_control_pkg;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      TRAP      = 3'd5
   } mc_state_type;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   function automatic logic is_legal_opc(input logic [6:0] opc);
      return opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH};
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The master side is the
// controller; the slave side is the datapath and memories that respond to it.
interface multicycle_control_if;
   logic [6:0]  opcode;
   logic        alu_zero;
   logic        imem_ack;
   logic        dmem_ack;
   logic        imem_req;
   logic        ir_write;
   logic        pc_write;
   logic        pc_src_branch;
   logic        reg_write;
   logic        mem_to_reg;
   logic        dmem_req;
   logic        dmem_we;
   logic        trap;
   logic [2:0]  state;
   logic [31:0] retired_count;

   modport master (
      input  opcode, alu_zero, imem_ack, dmem_ack,
      output imem_req, ir_write, pc_write, pc_src_branch, reg_write,
             mem_to_reg, dmem_req, dmem_we, trap, state, retired_count
   );

   modport slave (
      output opcode, alu_zero, imem_ack, dmem_ack,
      input  imem_req, ir_write, pc_write, pc_src_branch, reg_write,
             mem_to_reg, dmem_req, dmem_we, trap, state, retired_count
   );
endinterface

// File: rtl/multicycle_control_watchdog.sv
// Data-memory wait counter. expired flags the non-ack cycle that would bring
// the count up to MEM_TIMEOUT, so the FSM can leave MEMORY on that same edge.
module mc_watchdog #(
   parameter logic [7:0] MEM_TIMEOUT = 8'd64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   logic [7:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt <= '0;
      else if (clear) cnt <= '0;
      else if (tick)  cnt <= cnt + 8'd1;
   end

   assign expired = tick && (cnt >= MEM_TIMEOUT - 8'd1);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/TRAP.
// Optional retired-instruction counter under MULTICYCLE_CONTROL_PERF_EN.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter logic [7:0] MEM_TIMEOUT = 8'd64
) (
   input logic                  clk,
   input logic                  rst,
   multicycle_control_if.master bus
);

   mc_state_type state_q, state_d;
   logic         wd_expired;

   // The counter idles at zero outside MEMORY, so every MEMORY entry starts fresh.
   mc_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q != MEMORY),
      .tick    ((state_q == MEMORY) && !bus.dmem_ack),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:     if (bus.imem_ack) state_d = DECODE;
         DECODE:    state_d = is_legal_opc(bus.opcode) ? EXECUTE : TRAP;
         EXECUTE: begin
            case (bus.opcode)
               OPC_OP, OPC_OP_IMM:  state_d = WRITEBACK;
               OPC_LOAD, OPC_STORE: state_d = MEMORY;
               OPC_BRANCH:          state_d = FETCH;
               default:             state_d = TRAP;
            endcase
         end
         // Ack takes priority over a timeout landing in the same cycle.
         MEMORY: begin
            if (bus.dmem_ack)
               state_d = (bus.opcode == OPC_STORE) ? FETCH : WRITEBACK;
            else if (wd_expired)
               state_d = TRAP;
         end
         WRITEBACK: state_d = FETCH;
         TRAP:      state_d = TRAP;
         default:   state_d = TRAP;
      endcase
   end

   // Outputs are gated by rst so they drop immediately, not at the next edge.
   always_comb begin
      bus.imem_req      = 1'b0;
      bus.ir_write      = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_src_branch = 1'b0;
      bus.reg_write     = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.dmem_req      = 1'b0;
      bus.dmem_we       = 1'b0;
      bus.trap          = 1'b0;
      if (!rst) begin
         case (state_q)
            FETCH: begin
               bus.imem_req = 1'b1;
               if (bus.imem_ack) begin
                  bus.ir_write = 1'b1;
                  bus.pc_write = 1'b1;
               end
            end
            EXECUTE: begin
               if (bus.opcode == OPC_BRANCH && bus.alu_zero) begin
                  bus.pc_write      = 1'b1;
                  bus.pc_src_branch = 1'b1;
               end
            end
            MEMORY: begin
               bus.dmem_req = 1'b1;
               bus.dmem_we  = (bus.opcode == OPC_STORE);
            end
            WRITEBACK: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = (bus.opcode == OPC_LOAD);
            end
            TRAP:    bus.trap = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.state = state_q;

`ifdef MULTICYCLE_CONTROL_PERF_EN
   logic [31:0] retired_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         retired_q <= '0;
      else if (state_d == FETCH &&
               (state_q == EXECUTE || state_q == MEMORY || state_q == WRITEBACK))
         retired_q <= retired_q + 32'd1;
   end

   assign bus.retired_count = retired_q;
`else
   assign bus.retired_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4); per-cycle expectations
// are queued with their stimulus and checked as the DUT steps through them.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

`ifdef MULTICYCLE_CONTROL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // strobe order: imem_req ir_write pc_write pc_src reg_write mem_to_reg dmem_req dmem_we trap
   localparam logic [8:0] S_NONE  = 9'b000000000;
   localparam logic [8:0] S_FWAIT = 9'b100000000;
   localparam logic [8:0] S_FACK  = 9'b111000000;
   localparam logic [8:0] S_BRT   = 9'b001100000;
   localparam logic [8:0] S_MLD   = 9'b000000100;
   localparam logic [8:0] S_MST   = 9'b000000110;
   localparam logic [8:0] S_WBA   = 9'b000010000;
   localparam logic [8:0] S_WBL   = 9'b000011000;
   localparam logic [8:0] S_TRAP  = 9'b000000001;

   typedef struct {
      logic [6:0] opc;
      logic       ia, da, az;
      logic [2:0] st;
      logic [8:0] sb;
      string      tag;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_ret = 32'd0;
   rec_t        sbq[$];

   multicycle_control_if bus();

   multicycle_control #(.MEM_TIMEOUT(8'd4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, limit 200000");
      $fatal(1, "timeout");
   end

   function automatic logic [8:0] strobes();
      return {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src_branch, bus.reg_write,
              bus.mem_to_reg, bus.dmem_req, bus.dmem_we, bus.trap};
   endfunction

   task automatic push(input logic [6:0] opc, input logic ia, input logic da, input logic az,
                       input logic [2:0] st, input logic [8:0] sb, input string tag);
      rec_t r;
      r.opc = opc; r.ia = ia; r.da = da; r.az = az; r.st = st; r.sb = sb; r.tag = tag;
      sbq.push_back(r);
   endtask

   task automatic fetch_decode(input logic [6:0] opc, input string tag);
      push(opc, 1'b1, 1'b0, 1'b0, 3'd0, S_FACK, {tag, "_fetch"});
      push(opc, 1'b1, 1'b1, 1'b0, 3'd1, S_NONE, {tag, "_decode"});
   endtask

   // Called at a negedge; drives each record's inputs, checks, moves one cycle on.
   task automatic run();
      rec_t r;
      while (sbq.size() > 0) begin
         r = sbq.pop_front();
         bus.opcode = r.opc; bus.imem_ack = r.ia; bus.dmem_ack = r.da; bus.alu_zero = r.az;
         #1;
         tests++;
         assert ({bus.state, strobes()} === {r.st, r.sb}) else begin
            fails++;
            $error("FAIL %s: state/strobes got %0d/%b expected %0d/%b",
                   r.tag, bus.state, strobes(), r.st, r.sb);
         end
         @(negedge clk);
      end
   endtask

   task automatic check_ret(input string tag);
      logic [31:0] want;
      want = PERF ? exp_ret : 32'd0;
      tests++;
      assert (bus.retired_count === want) else begin
         fails++;
         $error("FAIL %s: retired_count got %0d expected %0d", tag, bus.retired_count, want);
      end
   endtask

   task automatic check_zero(input string tag);
      tests++;
      assert ({bus.state, strobes(), bus.retired_count} === 44'd0) else begin
         fails++;
         $error("FAIL %s: state/strobes/retired got %0d/%b/%0d expected 0/%b/0",
                tag, bus.state, strobes(), bus.retired_count, S_NONE);
      end
   endtask

   initial begin
      bus.opcode = OPC_OP; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.alu_zero = 1'b0;
      @(negedge clk);
      #1 check_zero("reset_state");
      @(negedge clk);
      rst = 1'b0;

      // ADD with both acks high: 0,1,2,4,0
      fetch_decode(OPC_OP, "add");
      push(OPC_OP, 1'b1, 1'b1, 1'b0, 3'd2, S_NONE,  "add_execute");
      push(OPC_OP, 1'b1, 1'b1, 1'b0, 3'd4, S_WBA,   "add_writeback");
      push(OPC_OP, 1'b0, 1'b1, 1'b0, 3'd0, S_FWAIT, "add_next_fetch");
      run(); exp_ret++; check_ret("add_retired");

      // LW, dmem_ack on the 4th MEMORY cycle (same cycle as the timeout)
      fetch_decode(OPC_LOAD, "lw");
      push(OPC_LOAD, 1'b0, 1'b0, 1'b0, 3'd2, S_NONE, "lw_execute");
      for (int i = 0; i < 3; i++) push(OPC_LOAD, 1'b1, 1'b0, 1'b0, 3'd3, S_MLD, "lw_mem_wait");
      push(OPC_LOAD, 1'b0, 1'b1, 1'b0, 3'd3, S_MLD,   "lw_mem_ack");
      push(OPC_LOAD, 1'b0, 1'b0, 1'b0, 3'd4, S_WBL,   "lw_writeback");
      push(OPC_LOAD, 1'b0, 1'b0, 1'b0, 3'd0, S_FWAIT, "lw_next_fetch");
      run(); exp_ret++; check_ret("lw_retired");

      // BEQ taken then not taken
      fetch_decode(OPC_BRANCH, "beq_t");
      push(OPC_BRANCH, 1'b0, 1'b0, 1'b1, 3'd2, S_BRT,   "beq_t_execute");
      push(OPC_BRANCH, 1'b0, 1'b0, 1'b1, 3'd0, S_FWAIT, "beq_t_next_fetch");
      run(); exp_ret++; check_ret("beq_t_retired");
      fetch_decode(OPC_BRANCH, "beq_nt");
      push(OPC_BRANCH, 1'b0, 1'b0, 1'b0, 3'd2, S_NONE,  "beq_nt_execute");
      push(OPC_BRANCH, 1'b0, 1'b0, 1'b0, 3'd0, S_FWAIT, "beq_nt_next_fetch");
      run(); exp_ret++; check_ret("beq_nt_retired");

      // OP-IMM with slow imem; stray dmem_ack while no dmem request is ignored
      push(OPC_OP_IMM, 1'b0, 1'b1, 1'b0, 3'd0, S_FWAIT, "addi_fetch_wait");
      push(OPC_OP_IMM, 1'b0, 1'b1, 1'b0, 3'd0, S_FWAIT, "addi_fetch_wait");
      fetch_decode(OPC_OP_IMM, "addi");
      push(OPC_OP_IMM, 1'b0, 1'b1, 1'b1, 3'd2, S_NONE,  "addi_execute");
      push(OPC_OP_IMM, 1'b0, 1'b1, 1'b0, 3'd4, S_WBA,   "addi_writeback");
      push(OPC_OP_IMM, 1'b0, 1'b0, 1'b0, 3'd0, S_FWAIT, "addi_next_fetch");
      run(); exp_ret++; check_ret("addi_retired");

      // SW, ack on MEMORY cycle 4 -> FETCH, no trap
      fetch_decode(OPC_STORE, "sw_ack4");
      push(OPC_STORE, 1'b0, 1'b0, 1'b0, 3'd2, S_NONE, "sw_ack4_execute");
      for (int i = 0; i < 3; i++) push(OPC_STORE, 1'b1, 1'b0, 1'b0, 3'd3, S_MST, "sw_ack4_mem_wait");
      push(OPC_STORE, 1'b0, 1'b1, 1'b0, 3'd3, S_MST,   "sw_ack4_mem_ack");
      push(OPC_STORE, 1'b0, 1'b0, 1'b0, 3'd0, S_FWAIT, "sw_ack4_next_fetch");
      run(); exp_ret++; check_ret("sw_retired");

      // SW, no ack -> TRAP after 4 MEMORY cycles, acks ignored in TRAP
      fetch_decode(OPC_STORE, "sw_to");
      push(OPC_STORE, 1'b0, 1'b0, 1'b0, 3'd2, S_NONE, "sw_to_execute");
      for (int i = 0; i < 4; i++) push(OPC_STORE, 1'b0, 1'b0, 1'b0, 3'd3, S_MST, "sw_to_mem_wait");
      for (int i = 0; i < 3; i++) push(OPC_STORE, 1'b1, 1'b1, 1'b1, 3'd5, S_TRAP, "sw_to_trap");
      run(); check_ret("sw_to_retired");

      // Reset out of TRAP clears everything asynchronously
      rst = 1'b1;
      #1 check_zero("rst_from_trap");
      exp_ret = 32'd0;
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of a load's MEMORY wait
      fetch_decode(OPC_LOAD, "lw_rst");
      push(OPC_LOAD, 1'b0, 1'b0, 1'b0, 3'd2, S_NONE, "lw_rst_execute");
      push(OPC_LOAD, 1'b0, 1'b0, 1'b0, 3'd3, S_MLD,  "lw_rst_mem");
      push(OPC_LOAD, 1'b0, 1'b0, 1'b0, 3'd3, S_MLD,  "lw_rst_mem");
      run();
      rst = 1'b1;
      #1 check_zero("rst_mid_memory");
      @(negedge clk);
      rst = 1'b0;

      // First cycle after release fetches; then an illegal opcode traps for good
      push(7'h7f, 1'b0, 1'b0, 1'b0, 3'd0, S_FWAIT, "post_rst_fetch");
      fetch_decode(7'h7f, "illegal");
      for (int i = 0; i < 100; i++)
         push(7'h7f, i[0], !i[0], 1'b1, 3'd5, S_TRAP, "illegal_trap_hold");
      run(); check_ret("illegal_retired");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
